operand_fetch_unit: RTL
=======================

Name: operand_fetch_unit

Overview:
- Requester side of the 8x16 register file interface: drives read/write addresses, write enable and write data into the regfile; captures its registered read data.
- Accepts decoded instructions (two sources, optional destination), fetches operands, presents them to the execute stage with valid/ready.
- Accepts writeback results and writes them to the regfile.
- Tracks in-flight destinations in an 8-bit scoreboard; issue stalls on read-after-write hazards.

Parameters:
- DW, 16, data width (matches regfile)
- AW, 3, register address width; NREG = 2**AW = 8

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decoded instruction valid
- iss_ready  out  1  unit can accept instruction
- iss_src_a  in  AW  source register A
- iss_src_b  in  AW  source register B
- iss_dst  in  AW  destination register
- iss_has_dst  in  1  instruction writes iss_dst
- op_valid  out  1  operands valid to execute
- op_ready  in  1  execute accepts operands
- op_a  out  DW  signed operand A
- op_b  out  DW  signed operand B
- op_dst  out  AW  destination forwarded with operands
- wb_valid  in  1  writeback result valid; always accepted, no ready
- wb_dst  in  AW  writeback register
- wb_data  in  DW  writeback data
- rf_addr_a  out  AW  regfile port A address (read A / write)
- rf_addr_b  out  AW  regfile port B address (read B)
- rf_we  out  1  regfile write enable
- rf_wdata  out  DW  regfile write data
- rf_data_a  in  DW  regfile read data A; registered, valid the cycle after its address
- rf_data_b  in  DW  regfile read data B; same timing as A
- busy  out  1  state != IDLE or scoreboard nonzero

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pending=0, op_valid=0, op_a=op_b=0, op_dst=0, latched src/dst=0.
  - rf_we forced 0 while rst_n low.
- States: IDLE, READ, WAIT, VALID.
- hazard = pending[iss_src_a] | pending[iss_src_b].
- iss_ready = (state==IDLE) & ~hazard.
- IDLE:
  - On iss_valid & iss_ready: latch src_a, src_b, dst, has_dst.
  - If has_dst, set pending[dst]. Go to READ.
- READ:
  - Drive rf_addr_a = latched src_a, rf_addr_b = latched src_b, rf_we=0.
  - If wb_valid, the write owns port A: stay in READ and retry next cycle.
  - Otherwise go to WAIT.
- WAIT:
  - rf_data_a/b reflect the READ-cycle addresses.
  - At the closing edge: op_a <= rf_data_a, op_b <= rf_data_b, op_dst <= latched dst, op_valid <= 1. Go to VALID.
- VALID:
  - Hold op_a/op_b/op_dst stable while op_valid & ~op_ready.
  - On op_ready: op_valid <= 0, go to IDLE.
  - No back-to-back overlap: the next issue is accepted in IDLE at the earliest.
- Latency: accept edge to op_valid high is 3 edges, plus one cycle per READ retry.
- Port A arbitration:
  - In every state except READ-without-wb: rf_addr_a = wb_dst, rf_we = wb_valid, rf_wdata = wb_data.
  - In READ with wb_valid: the write is performed (same muxing); the read is retried.
  - rf_addr_b = latched src_b in all states.
- Scoreboard:
  - wb_valid clears pending[wb_dst].
  - Same-edge set and clear of the same index: set wins.
  - wb to a non-pending register: write performed, pending unchanged.
- Signed data is passed through unmodified; no arithmetic in this block.
- rst_n asserted mid-operation: in-flight instruction and scoreboard discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: OFU_WB_WAKEUP_EN.
- Defined:
  - A pending source equal to wb_dst while wb_valid is not a hazard.
  - The issue is accepted in that same cycle; the write completes at that edge, so the READ cycle reads the new value.
  - Saves one stall cycle.
- Undefined: the hazard uses pending only; issue waits until the cycle after the writeback.

Test Plan:
- Reset, then write regs 1 and 2 via wb (0x1234, 0xFFF0); issue src_a=1, src_b=2, dst=3, has_dst=1, op_ready=1 -> op_valid 3 edges after accept with op_a=0x1234, op_b=0xFFF0 (-16), op_dst=3; pending[3]=1.
- RAW stall: with pending[3]=1, issue src_a=3 -> iss_ready=0 until wb_dst=3, wb_data=0x0042 -> issue accepted the cycle after wb (same cycle with OFU_WB_WAKEUP_EN); op_a=0x0042.
- wb_valid held high 2 cycles during READ (dst 5) -> READ retried 2 cycles; rf_we=1 with rf_addr_a=5 in those cycles; the operands returned are correct.
- op_ready=0 for 4 cycles in VALID, wb writing the source register meanwhile -> op_a/op_b stay stable; op_valid stays high; iss_ready=0 throughout.
- Same-edge issue with dst=4 and wb_dst=4 -> pending[4]=1 after the edge.
- Assert rst_n low during WAIT -> op_valid=0, pending=0, rf_we=0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand fetch: reads two sources from the 8x16 regfile, presents them to execute, and
// stalls on RAW hazards. OFU_WB_WAKEUP_EN lets a same-cycle writeback clear a source hazard.
module operand_fetch_unit #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_src_a,
  input  logic [AW-1:0] iss_src_b,
  input  logic [AW-1:0] iss_dst,
  input  logic          iss_has_dst,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [AW-1:0] op_dst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] rf_addr_a,
  output logic [AW-1:0] rf_addr_b,
  output logic          rf_we,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_data_a,
  input  logic [DW-1:0] rf_data_b,
  output logic          busy
);

  localparam int unsigned NREG = 2**AW;

  typedef enum logic [1:0] {IDLE, READ, WAIT, VALID} state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [AW-1:0]   src_a_q, src_a_d;
  logic [AW-1:0]   src_b_q, src_b_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic            op_valid_d;
  logic [DW-1:0]   op_a_d, op_b_d;
  logic [AW-1:0]   op_dst_d;
  logic            hazard_a, hazard_b;
  logic            accept;
  logic            read_grant;

`ifdef OFU_WB_WAKEUP_EN
  // A source being written back this cycle is ready by the time READ samples it.
  assign hazard_a = pending_q[iss_src_a] & ~(wb_valid & (wb_dst == iss_src_a));
  assign hazard_b = pending_q[iss_src_b] & ~(wb_valid & (wb_dst == iss_src_b));
`else
  assign hazard_a = pending_q[iss_src_a];
  assign hazard_b = pending_q[iss_src_b];
`endif

  assign iss_ready  = (state_q == IDLE) & ~(hazard_a | hazard_b);
  assign accept     = iss_valid & iss_ready;

  // Port A belongs to the writeback except in a READ cycle with no write pending.
  assign read_grant = (state_q == READ) & ~wb_valid;
  assign rf_addr_a  = read_grant ? src_a_q : wb_dst;
  assign rf_addr_b  = src_b_q;
  assign rf_we      = wb_valid & rst_n;
  assign rf_wdata   = wb_data;
  assign busy       = (state_q != IDLE) | (|pending_q);

  // Next-state, scoreboard and operand capture.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    op_valid_d = op_valid;
    op_a_d     = op_a;
    op_b_d     = op_b;
    op_dst_d   = op_dst;

    // Clear before set so a same-edge issue to the written register keeps it pending.
    if (wb_valid) pending_d[wb_dst] = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          src_a_d = iss_src_a;
          src_b_d = iss_src_b;
          dst_d   = iss_dst;
          if (iss_has_dst) pending_d[iss_dst] = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (!wb_valid) state_d = WAIT;
      end
      WAIT: begin
        op_a_d     = rf_data_a;
        op_b_d     = rf_data_b;
        op_dst_d   = dst_q;
        op_valid_d = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_dst    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      op_valid  <= op_valid_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      op_dst    <= op_dst_d;
    end
  end

endmodule
